// File: rtl/module_spi_tx_master.sv
// SPI mode-0 (CPOL=0, CPHA=0) master transmit engine with a per-bit RX sample strobe.
// Build option: define SPI_TX_LSB_FIRST_EN to send bit 0 first (register shifts right).
module module_spi_tx_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic                  sclk_o,
  output logic                  cs_n_o,
  output logic                  mosi_o,
  output logic                  sample_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD
  } state_t;

  state_t                r_state;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_ready;
  logic                  r_done;
  logic                  r_sclk;
  logic                  r_cs_n;
  logic                  r_sample;

  logic                  w_div_last;
  logic                  w_tx_bit;
  logic [DATA_WIDTH-1:0] w_shift_next;

  assign w_div_last = (r_div_cnt == DIV_LAST);

  // The outgoing bit always sits at the transmit end of the shift register,
  // so MOSI comes straight from a flop and clears when the register clears.
`ifdef SPI_TX_LSB_FIRST_EN
  assign w_tx_bit     = r_shift[0];
  assign w_shift_next = {1'b0, r_shift[DATA_WIDTH-1:1]};
`else
  assign w_tx_bit     = r_shift[DATA_WIDTH-1];
  assign w_shift_next = {r_shift[DATA_WIDTH-2:0], 1'b0};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_sample  <= 1'b0;
    end else begin
      // NOTE: these defaults are non-blocking, so a later assignment in the
      // case below overrides them; the last scheduled update wins.
      r_done   <= 1'b0;
      r_sample <= 1'b0;

      if (r_state != S_IDLE) begin
        r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_shift   <= data_i;
            r_cs_n    <= 1'b0;
            r_ready   <= 1'b0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_state   <= S_SETUP;
          end
        end

        S_SETUP, S_LOW: begin
          if (w_div_last) begin
            r_sclk   <= 1'b1;
            r_sample <= 1'b1;
            r_state  <= S_HIGH;
          end
        end

        S_HIGH: begin
          if (w_div_last) begin
            r_sclk <= 1'b0;
            // Shifting on the falling edge keeps MOSI stable across each rising edge.
            if (r_bit_cnt == BIT_LAST) begin
              r_state <= S_HOLD;
            end else begin
              r_shift   <= w_shift_next;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_state   <= S_LOW;
            end
          end
        end

        S_HOLD: begin
          if (w_div_last) begin
            r_cs_n  <= 1'b1;
            r_shift <= '0;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o  = r_ready;
  assign done_o   = r_done;
  assign sclk_o   = r_sclk;
  assign cs_n_o   = r_cs_n;
  assign mosi_o   = w_tx_bit;
  assign sample_o = r_sample;

endmodule

// File: tb/tb_module_spi_tx_master.sv
// Self-checking bench for module_spi_tx_master: two instances (CLK_DIV=2 and CLK_DIV=1)
// observed through a frame-level monitor and compared with a bit-order reference model.
module tb_module_spi_tx_master;

  localparam int DW = 8;

  typedef struct {
    int             cs_cycles;
    int             samples;
    int             rises;
    int             sclk_same;
    int             mosi_bad;
    int             sample_bad;
    int             gap;
    logic [DW-1:0]  bits;
    logic [DW-1:0]  rx;
    logic           done_at_end;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [DW-1:0] data;
  logic          sel;

  logic          start_s, ready_s, done_s, sclk_s, cs_n_s, mosi_s, sample_s;
  logic          start_f, ready_f, done_f, sclk_f, cs_n_f, mosi_f, sample_f;
  logic          v_ready, v_done, v_sclk, v_cs_n, v_mosi, v_sample;

  assign start_s  = start & ~sel;
  assign start_f  = start & sel;
  assign v_ready  = sel ? ready_f  : ready_s;
  assign v_done   = sel ? done_f   : done_s;
  assign v_sclk   = sel ? sclk_f   : sclk_s;
  assign v_cs_n   = sel ? cs_n_f   : cs_n_s;
  assign v_mosi   = sel ? mosi_f   : mosi_s;
  assign v_sample = sel ? sample_f : sample_s;

  module_spi_tx_master #(.DATA_WIDTH(DW), .CLK_DIV(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_s), .data_i(data),
    .ready_o(ready_s), .done_o(done_s), .sclk_o(sclk_s), .cs_n_o(cs_n_s),
    .mosi_o(mosi_s), .sample_o(sample_s)
  );

  module_spi_tx_master #(.DATA_WIDTH(DW), .CLK_DIV(1)) dut_fast (
    .clk_i(clk), .rst_i(rst), .start_i(start_f), .data_i(data),
    .ready_o(ready_f), .done_o(done_f), .sclk_o(sclk_f), .cs_n_o(cs_n_f),
    .mosi_o(mosi_f), .sample_o(sample_f)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: order in which the word's bits must appear on MOSI, first bit at MSB.
  function automatic logic [DW-1:0] tx_order(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) begin
`ifdef SPI_TX_LSB_FIRST_EN
      r[DW-1-i] = d[i];
`else
      r[DW-1-i] = d[DW-1-i];
`endif
    end
    return r;
  endfunction

  // Frame monitor, sampling on the falling clock edge.
  frame_t cur;
  frame_t frames[$];
  int     high_run = 0;
  int     done_cnt = 0;
  int     idle_bad = 0;
  logic   p_cs_n = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;

  initial begin
    cur = '{default: 0};
    forever begin
      @(negedge clk);
      if (!v_cs_n) begin
        if (p_cs_n) begin
          cur     = '{default: 0};
          cur.gap = high_run;
        end
        cur.cs_cycles++;
        if (v_sclk && !p_sclk) cur.rises++;
        if (!p_cs_n && v_sclk == p_sclk) cur.sclk_same++;
        if (v_sample) begin
          cur.samples++;
          cur.bits = {cur.bits[DW-2:0], v_mosi};
`ifdef SPI_TX_LSB_FIRST_EN
          cur.rx = {v_mosi, cur.rx[DW-1:1]};
`else
          cur.rx = {cur.rx[DW-2:0], v_mosi};
`endif
        end
        if (v_sample != (v_sclk && !p_sclk)) cur.sample_bad++;
        if (!p_cs_n && v_mosi != p_mosi && !(p_sclk && !v_sclk)) cur.mosi_bad++;
        high_run = 0;
      end else begin
        if (v_sclk || v_sample) idle_bad++;
        if (!p_cs_n) begin
          cur.done_at_end = v_done;
          frames.push_back(cur);
        end
        high_run++;
      end
      if (v_done) done_cnt++;
      p_cs_n = v_cs_n;
      p_sclk = v_sclk;
      p_mosi = v_mosi;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frame(input string tag, output frame_t f);
    int i;
    f = '{default: 0};
    for (i = 0; i < 300 && frames.size() == 0; i++) step();
    if (frames.size() == 0) check({tag, ".frame_timeout"}, 32'd0, 32'd1);
    else f = frames.pop_front();
  endtask

  task automatic check_frame(input string tag, input frame_t f, input logic [DW-1:0] d,
                             input int div);
    check({tag, ".cs_len"},     f.cs_cycles,   (2*DW+1)*div);
    check({tag, ".samples"},    f.samples,     DW);
    check({tag, ".sclk_rises"}, f.rises,       DW);
    check({tag, ".mosi_bits"},  f.bits,        tx_order(d));
    check({tag, ".rx_word"},    f.rx,          d);
    check({tag, ".mosi_edges"}, f.mosi_bad,    0);
    check({tag, ".sample_pos"}, f.sample_bad,  0);
    check({tag, ".done_pulse"}, f.done_at_end, 1);
  endtask

  task automatic pulse_start(input logic [DW-1:0] d);
    data  = d;
    start = 1'b1;
    step();
    start = 1'b0;
    data  = DW'($urandom);
  endtask

  initial begin
    frame_t        f, f2;
    int            d0;
    logic          found;
    logic [DW-1:0] rd;

    rst = 1'b1; start = 1'b0; data = '0; sel = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Idle after reset: ready=1, done=0, sclk=0, cs_n=1, mosi=0, sample=0.
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_outputs", {v_ready, v_done, v_sclk, v_cs_n, v_mosi, v_sample}, 6'b100100);
    end

    // Single frame 8'hA5 at CLK_DIV=2; data_i scrambled after accept.
    d0 = done_cnt;
    pulse_start(8'hA5);
    check("a5.ready_busy", v_ready, 1'b0);
    wait_frame("a5", f);
    check_frame("a5", f, 8'hA5, 2);
    check("a5.done_count", done_cnt - d0, 1);
    check("a5.ready_after", v_ready, 1'b1);

    // Back-to-back 8'h3C frames at CLK_DIV=1 with start held across done.
    repeat (2) step();
    sel = 1'b1; data = 8'h3C; start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      found = v_done;
    end
    check("b2b.first_done_seen", found, 1'b1);
    step();
    start = 1'b0;
    wait_frame("b2b1", f);
    check_frame("b2b1", f, 8'h3C, 1);
    check("b2b1.sclk_toggle", f.sclk_same, 0);
    wait_frame("b2b2", f2);
    check_frame("b2b2", f2, 8'h3C, 1);
    check("b2b2.cs_gap", f2.gap, 1);
    check("b2b2.sclk_toggle", f2.sclk_same, 0);
    repeat (20) step();
    check("b2b.no_third", frames.size(), 0);

    // start with 8'hFF while 8'h01 is in flight is ignored.
    sel = 1'b0;
    pulse_start(8'h01);
    repeat (5) step();
    data = 8'hFF; start = 1'b1;
    repeat (10) step();
    start = 1'b0;
    wait_frame("busy", f);
    check_frame("busy", f, 8'h01, 2);
    repeat (40) step();
    check("busy.no_extra", frames.size(), 0);
    check("busy.cs_idle", v_cs_n, 1'b1);

    // Reset at the 4th sample pulse aborts the frame without done.
    d0 = done_cnt;
    pulse_start(8'h81);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      found = v_sample && (cur.samples == 4);
    end
    check("abort.reached_4th", found, 1'b1);
    rst = 1'b1;
    step();
    check("abort.outputs", {v_ready, v_done, v_sclk, v_cs_n, v_sample}, 5'b10010);
    rst = 1'b0;
    wait_frame("abort", f);
    check("abort.no_done", f.done_at_end, 1'b0);
    check("abort.samples", f.samples, 4);
    check("abort.done_count", done_cnt - d0, 0);
    step();
    pulse_start(8'h81);
    wait_frame("after_abort", f);
    check_frame("after_abort", f, 8'h81, 2);

    // Random frames on either instance.
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 3)) step();
      sel = 1'($urandom_range(0, 1));
      rd  = DW'($urandom);
      pulse_start(rd);
      wait_frame($sformatf("rand%0d", k), f);
      check_frame($sformatf("rand%0d", k), f, rd, sel ? 1 : 2);
    end

    step();
    check("idle_sclk_sample", idle_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/module_spi_tx_master.md
Name: module_spi_tx_master

Overview:
SPI mode 0 (CPOL=0, CPHA=0) master transmit engine.
- Accepts a parallel word on a start/ready handshake.
- Generates SCLK and active-low chip select, and shifts the word out on MOSI.
- Issues a per-bit sample strobe that drives the shift enable of the companion receive shift register, so that register captures MISO in lockstep.

Parameters:
DATA_WIDTH, 8, bits per frame; must be >= 2.
CLK_DIV, 4, clk_i cycles per SCLK half-period; must be >= 1.

Ports:
clk_i  input  1  system clock; all logic on its rising edge.
rst_i  input  1  synchronous, active-high reset.
start_i  input  1  request a frame; accepted only when ready_o=1.
data_i  input  DATA_WIDTH  word to transmit; captured on the accept cycle.
ready_o  output  1  engine idle, able to accept start_i.
done_o  output  1  single-cycle pulse at end of frame.
sclk_o  output  1  SPI clock; idles low.
cs_n_o  output  1  chip select, active low.
mosi_o  output  1  serial data out.
sample_o  output  1  single-cycle pulse in the cycle sclk_o first reads 1 for each bit; drives the RX shift_en.

Behaviour:
- All outputs are registered.
- Reset values: ready_o=1, done_o=0, sclk_o=0, cs_n_o=1, mosi_o=0, sample_o=0. State is IDLE; counters and shift register are 0.
- Reset wins over every other input, including mid-frame. The next edge aborts the frame with no done_o pulse, and cs_n_o reads 1 on the cycle after reset.
- States: IDLE, SETUP, HIGH, LOW, HOLD.
- A half-period counter counts 0..CLK_DIV-1 in SETUP/HIGH/LOW/HOLD. A state transition occurs on the edge where the counter equals CLK_DIV-1; the counter then reloads to 0.
- IDLE:
  - On start_i=1, capture data_i into the shift register, set cs_n_o=0, drive mosi_o with the first bit (MSB), clear ready_o and bit_cnt, then go to SETUP.
  - start_i=0 holds all outputs.
- SETUP:
  - sclk_o=0, MOSI stable.
  - At terminal count: sclk_o<=1, sample_o<=1, go to HIGH.
- HIGH:
  - sample_o is high only in the first cycle.
  - At terminal count, sclk_o<=0.
  - If bit_cnt=DATA_WIDTH-1, go to HOLD.
  - Otherwise shift, drive the next bit on mosi_o, increment bit_cnt, and go to LOW.
  - MOSI therefore changes only on falling SCLK.
- LOW:
  - At terminal count: sclk_o<=1, sample_o<=1, go to HIGH.
- HOLD:
  - cs_n_o=0, sclk_o=0, mosi_o holds the last bit.
  - At terminal count: cs_n_o<=1, mosi_o<=0, done_o<=1 for one cycle, ready_o<=1, go to IDLE.
- Timing:
  - cs_n_o is low for exactly (2*DATA_WIDTH+1)*CLK_DIV cycles.
  - Exactly DATA_WIDTH rising SCLK edges and DATA_WIDTH sample_o pulses per frame.
- start_i while ready_o=0 is ignored, and data_i is not re-sampled.
- start_i in the same cycle done_o/ready_o reads 1 is accepted. The new frame begins with cs_n_o low on the next cycle, giving a 1-cycle cs_n_o high gap.
- Changes to data_i after the accept cycle have no effect on the frame in flight.

Optional Feature:
Macro SPI_TX_LSB_FIRST_EN.
- Defined: bit 0 is transmitted first and the register shifts right.
- Undefined (default): MSB first and the register shifts left.
- Frame timing, handshake and sample_o are identical in both builds.

Test Plan:
1. Reset, then idle 10 cycles -> ready_o=1, cs_n_o=1, sclk_o=0, mosi_o=0, done_o=0 throughout.
2. DATA_WIDTH=8, CLK_DIV=2, start_i pulse with data_i=8'hA5 -> cs_n_o low 34 cycles; MOSI at each sample_o pulse reads 1,0,1,0,0,1,0,1; 8 sample_o pulses; one done_o pulse; the loopback RX shift register holds 8'hA5.
3. CLK_DIV=1, data_i=8'h3C, with start_i held high across done_o -> two back-to-back frames with a 1-cycle cs_n_o gap; sclk_o toggles every cycle; MOSI edges coincide only with falling sclk_o.
4. start_i=1 with data_i=8'hFF mid-frame (frame 8'h01 in flight) -> ignored; the frame still transmits 8'h01; no extra frame follows.
5. Assert rst_i at the 4th sample_o pulse -> next cycle cs_n_o=1, sclk_o=0, ready_o=1, no done_o; a following frame of 8'h81 transmits correctly.
6. Build with SPI_TX_LSB_FIRST_EN, data_i=8'h01, CLK_DIV=2 -> MOSI at sample pulses reads 1,0,0,0,0,0,0,0; cs_n_o low 34 cycles.
